// File: rtl/layer_sched_pkg.sv
// Shared types and defaults for the layer scheduler: FSM state encoding,
// queued command layout and parameter defaults.
package globals_sv;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TO_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4,
    S_REPORT = 3'd5
  } state_e;

  typedef struct packed {
    logic       sel;
    logic [3:0] rpt;
  } cmd_t;

  // Number of runs a command asks for; one wider than rpt so 16 fits.
  function automatic logic [4:0] runs_target(input logic [3:0] rpt);
    return {1'b0, rpt} + 5'd1;
  endfunction

endpackage

// File: rtl/layer_sched_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of cmd_t, with a flush that
// outranks push and pop.
module cmd_fifo
  import globals_sv::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic ck,
  input  logic rst,
  input  logic flush_i,
  input  logic push_i,
  input  cmd_t wdata_i,
  input  logic pop_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign rdata_o   = mem_q[rptr_q];

  always_ff @(posedge ck) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push_s) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: queues host commands, drives repeated NPU start/done
// handshakes per command with a watchdog, and returns one status record each.
module layer_sched
  import globals_sv::*;
#(
  parameter int unsigned       DEPTH  = DEPTH_DEF,
  parameter int unsigned       TO_W   = TO_W_DEF,
  parameter logic [TO_W-1:0]   TO_MAX = 16'hFFFF
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_c1_c2_n,
  input  logic [3:0] cmd_rpt,
  input  logic       abort,
  output logic       npu_start,
  output logic       npu_c1_c2_n,
  input  logic       npu_done,
  output logic       busy,
  output logic       sts_valid,
  input  logic       sts_ready,
  output logic       sts_err,
  output logic [4:0] sts_runs
);

  state_e          state_q;
  logic            sel_q;
  logic [3:0]      rpt_q;
  logic [4:0]      run_cnt_q;
  logic [TO_W-1:0] timer_q;
  logic            done_q;
  logic            npu_start_q;
  logic            busy_q;
  logic            sts_valid_q;
  logic            sts_err_q;
  logic [4:0]      sts_runs_q;

  cmd_t            head_s;
  cmd_t            wdata_s;
  logic            full_s;
  logic            empty_s;
  logic            pop_s;
  logic            done_rise_s;
  logic [4:0]      run_cnt_d;
  logic [TO_W-1:0] timer_d;

  assign wdata_s     = '{sel: cmd_c1_c2_n, rpt: cmd_rpt};
  assign cmd_ready   = !full_s;
  assign pop_s       = (state_q == S_LOAD);
  assign done_rise_s = npu_done && !done_q;
  assign run_cnt_d   = run_cnt_q + 5'd1;
  assign timer_d     = timer_q + TO_W'(1);

  assign npu_start   = npu_start_q;
  assign npu_c1_c2_n = sel_q;
  assign busy        = busy_q;
  assign sts_valid   = sts_valid_q;
  assign sts_err     = sts_err_q;
  assign sts_runs    = sts_runs_q;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck      (ck),
    .rst     (rst),
    .flush_i (abort),
    .push_i  (cmd_valid),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Done history runs in every state so WAIT sees a clean rising edge.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= npu_done;
    end
  end

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b1;
      rpt_q       <= 4'd0;
      run_cnt_q   <= 5'd0;
      timer_q     <= '0;
      npu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_err_q   <= 1'b0;
      sts_runs_q  <= 5'd0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      npu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      sts_valid_q <= 1'b0;
    end else begin
      npu_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_s) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          sel_q       <= head_s.sel;
          rpt_q       <= head_s.rpt;
          run_cnt_q   <= 5'd0;
          timer_q     <= '0;
          state_q     <= S_START;
          npu_start_q <= 1'b1;
        end
        S_START: begin
          timer_q <= timer_d;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_d;
          // A done edge beats a coincident timeout.
          if (done_rise_s) begin
            run_cnt_q <= run_cnt_d;
            if (run_cnt_d == runs_target(rpt_q)) begin
              state_q     <= S_REPORT;
              sts_valid_q <= 1'b1;
              sts_err_q   <= 1'b0;
              sts_runs_q  <= run_cnt_d;
            end else begin
              state_q <= S_GAP;
            end
          end else if (timer_d == TO_MAX) begin
            state_q     <= S_REPORT;
            sts_valid_q <= 1'b1;
            sts_err_q   <= 1'b1;
            sts_runs_q  <= run_cnt_q;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_GAP: begin
          timer_q     <= '0;
          state_q     <= S_START;
          npu_start_q <= 1'b1;
        end
        S_REPORT: begin
          if (sts_ready) begin
            state_q     <= S_IDLE;
            sts_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: latency, repeats, FIFO full, watchdog,
// abort and mid-run reset, each with hand-derived expectations.
module tb_layer_sched;

  logic       ck = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_c1_c2_n;
  logic [3:0] cmd_rpt;
  logic       abort;
  logic       npu_start;
  logic       npu_c1_c2_n;
  logic       npu_done;
  logic       busy;
  logic       sts_valid;
  logic       sts_ready;
  logic       sts_err;
  logic [4:0] sts_runs;

  int total  = 0;
  int passed = 0;
  int pulses = 0;

  layer_sched #(.DEPTH(4), .TO_W(16), .TO_MAX(16'd20)) dut (
    .ck          (ck),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_c1_c2_n (cmd_c1_c2_n),
    .cmd_rpt     (cmd_rpt),
    .abort       (abort),
    .npu_start   (npu_start),
    .npu_c1_c2_n (npu_c1_c2_n),
    .npu_done    (npu_done),
    .busy        (busy),
    .sts_valid   (sts_valid),
    .sts_ready   (sts_ready),
    .sts_err     (sts_err),
    .sts_runs    (sts_runs)
  );

  always #5 ck = ~ck;

  always @(posedge ck) begin
    if (npu_start === 1'b1) pulses = pulses + 1;
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic sel, input logic [3:0] rpt);
    cmd_valid   = 1'b1;
    cmd_c1_c2_n = sel;
    cmd_rpt     = rpt;
    step();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (npu_start !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    chk("start_seen", {31'd0, npu_start}, 32'd1);
  endtask

  // Single-run command: done rises two WAIT cycles after the pulse.
  task automatic serve(input logic exp_sel, input bit ack);
    wait_start();
    chk("serve_sel", {31'd0, npu_c1_c2_n}, {31'd0, exp_sel});
    step();
    step();
    npu_done = 1'b1;
    step();
    chk("serve_valid", {31'd0, sts_valid}, 32'd1);
    chk("serve_runs", {27'd0, sts_runs}, 32'd1);
    chk("serve_err", {31'd0, sts_err}, 32'd0);
    npu_done = 1'b0;
    if (ack) begin
      sts_ready = 1'b1;
      step();
      sts_ready = 1'b0;
      chk("serve_ack", {31'd0, sts_valid}, 32'd0);
    end
  endtask

  initial begin
    int p0;
    logic [4:0] sel_pat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_c1_c2_n = 1'b0; cmd_rpt = 4'd0;
    abort = 1'b0; npu_done = 1'b0; sts_ready = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_start", {31'd0, npu_start}, 32'd0);
    chk("rst_sel", {31'd0, npu_c1_c2_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, sts_valid}, 32'd0);
    chk("rst_err", {31'd0, sts_err}, 32'd0);
    chk("rst_runs", {27'd0, sts_runs}, 32'd0);
    rst = 1'b0;
    step();

    // One command, sel=1 rpt=0: LOAD at t+1, START at t+2, done at S+10.
    p0 = pulses;
    push(1'b1, 4'd0);
    chk("t1_idle_after_push", {31'd0, busy}, 32'd0);
    step();
    chk("t1_load_busy", {31'd0, busy}, 32'd1);
    chk("t1_load_nostart", {31'd0, npu_start}, 32'd0);
    step();
    chk("t1_start", {31'd0, npu_start}, 32'd1);
    chk("t1_sel", {31'd0, npu_c1_c2_n}, 32'd1);
    repeat (9) step();
    chk("t1_wait_novalid", {31'd0, sts_valid}, 32'd0);
    step();
    npu_done = 1'b1;
    step();
    chk("t1_valid", {31'd0, sts_valid}, 32'd1);
    chk("t1_runs", {27'd0, sts_runs}, 32'd1);
    chk("t1_err", {31'd0, sts_err}, 32'd0);
    chk("t1_pulses", pulses - p0, 32'd1);
    npu_done = 1'b0;
    sts_ready = 1'b1;
    step();
    sts_ready = 1'b0;
    chk("t1_ack_valid", {31'd0, sts_valid}, 32'd0);
    chk("t1_ack_busy", {31'd0, busy}, 32'd0);

    // rpt=3: four pulses, each after a one-cycle GAP.
    p0 = pulses;
    push(1'b0, 4'd3);
    wait_start();
    chk("t2_sel", {31'd0, npu_c1_c2_n}, 32'd0);
    for (int r = 1; r <= 4; r++) begin
      repeat (3) step();
      npu_done = 1'b1;
      step();
      if (r < 4) begin
        chk("t2_gap_nostart", {31'd0, npu_start}, 32'd0);
        chk("t2_gap_novalid", {31'd0, sts_valid}, 32'd0);
        npu_done = 1'b0;
        step();
        chk("t2_restart", {31'd0, npu_start}, 32'd1);
      end
    end
    chk("t2_valid", {31'd0, sts_valid}, 32'd1);
    chk("t2_runs", {27'd0, sts_runs}, 32'd4);
    chk("t2_err", {31'd0, sts_err}, 32'd0);
    chk("t2_pulses", pulses - p0, 32'd4);
    npu_done = 1'b0;
    sts_ready = 1'b1;
    step();
    sts_ready = 1'b0;

    // Five pushes while stalled in REPORT: the fifth is held off.
    push(1'b1, 4'd0);
    serve(1'b1, 1'b0);
    sel_pat = 5'b10101;
    cmd_valid = 1'b1;
    cmd_rpt = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cmd_c1_c2_n = sel_pat[i];
      chk("t3_ready_before_push", {31'd0, cmd_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    cmd_valid = 1'b0;
    chk("t3_full", {31'd0, cmd_ready}, 32'd0);
    chk("t3_stalled", {31'd0, sts_valid}, 32'd1);
    sts_ready = 1'b1;
    step();
    sts_ready = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 4; i++) serve(sel_pat[i], 1'b1);
    repeat (6) step();
    chk("t3_drained_busy", {31'd0, busy}, 32'd0);
    chk("t3_drained_pulses", pulses - p0, 32'd4);

    // Watchdog: done never rises, REPORT 20 cycles after the pulse.
    push(1'b1, 4'd2);
    wait_start();
    repeat (19) step();
    chk("t4_pre_timeout", {31'd0, sts_valid}, 32'd0);
    step();
    chk("t4_valid", {31'd0, sts_valid}, 32'd1);
    chk("t4_err", {31'd0, sts_err}, 32'd1);
    chk("t4_runs", {27'd0, sts_runs}, 32'd0);
    sts_ready = 1'b1;
    step();
    sts_ready = 1'b0;

    // Abort in WAIT with two queued, plus a same-cycle push.
    push(1'b0, 4'd0);
    wait_start();
    push(1'b1, 4'd1);
    push(1'b0, 4'd2);
    chk("t5_wait_busy", {31'd0, busy}, 32'd1);
    p0 = pulses;
    abort = 1'b1;
    cmd_valid = 1'b1;
    step();
    abort = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_nostart", {31'd0, npu_start}, 32'd0);
    chk("t5_novalid", {31'd0, sts_valid}, 32'd0);
    chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (5) step();
    chk("t5_empty_busy", {31'd0, busy}, 32'd0);
    chk("t5_no_pulses", pulses - p0, 32'd0);
    chk("t5_no_status", {31'd0, sts_valid}, 32'd0);

    // Reset during WAIT, then a fresh command runs normally.
    push(1'b0, 4'd0);
    wait_start();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t6_rst_start", {31'd0, npu_start}, 32'd0);
    chk("t6_rst_sel", {31'd0, npu_c1_c2_n}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_valid", {31'd0, sts_valid}, 32'd0);
    chk("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    push(1'b0, 4'd0);
    serve(1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
